// File: rtl/hm_nonce_sequencer.sv
// Nonce sequencer in front of a SHA-256 compression core: midstate once per job,
// then per nonce a block-B pass (and optionally a block-C pass) and a target compare.
module hm_nonce_sequencer #(
  parameter int CORE_TIMEOUT = 128,
  parameter bit DOUBLE_HASH  = 1'b1
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         start,
  input  logic         abort,
  input  logic [639:0] header,
  input  logic [31:0]  nonce_start,
  input  logic [31:0]  nonce_end,
  input  logic [255:0] target,
  output logic         core_start,
  output logic [511:0] core_block,
  output logic [255:0] core_iv,
  input  logic         core_done,
  input  logic [255:0] core_hash,
  output logic         busy,
  output logic         found,
  output logic         exhausted,
  output logic         err,
  output logic [31:0]  nonce_out,
  output logic [255:0] hash_out,
  output logic [31:0]  hash_count
);

  localparam logic [255:0] STD_IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam int TW = $clog2(CORE_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(CORE_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, MID, HASH1, HASH2, CHECK} state_t;

  state_t         state;
  logic [639:0]   hdr;
  logic [255:0]   tgt;
  logic [31:0]    nonce;
  logic [31:0]    n_end;
  logic [255:0]   mid;
  logic [255:0]   h_r;
  logic [TW-1:0]  tmo;

  assign busy = (state != IDLE);

  // Block/IV are decoded from latched job state, so they hold steady for a whole pass.
  always_comb begin
    core_block = '0;
    core_iv    = '0;
    case (state)
      MID: begin
        core_block = hdr[639:128];
        core_iv    = STD_IV;
      end
      HASH1: begin
        core_block = {hdr[127:32], nonce, 32'h80000000, 320'h0, 32'h00000280};
        core_iv    = mid;
      end
      HASH2: begin
        core_block = {h_r, 32'h80000000, 192'h0, 32'h00000100};
        core_iv    = STD_IV;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      hdr        <= '0;
      tgt        <= '0;
      nonce      <= '0;
      n_end      <= '0;
      mid        <= '0;
      h_r        <= '0;
      tmo        <= '0;
      core_start <= 1'b0;
      found      <= 1'b0;
      exhausted  <= 1'b0;
      err        <= 1'b0;
      nonce_out  <= '0;
      hash_out   <= '0;
      hash_count <= '0;
    end else begin
      core_start <= 1'b0;
      if (abort) begin
        state     <= IDLE;
        found     <= 1'b0;
        exhausted <= 1'b0;
        err       <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            hdr        <= header;
            tgt        <= target;
            nonce      <= nonce_start;
            n_end      <= nonce_end;
            found      <= 1'b0;
            exhausted  <= 1'b0;
            err        <= 1'b0;
            hash_count <= '0;
            tmo        <= '0;
            core_start <= 1'b1;
            state      <= MID;
          end
          MID, HASH1, HASH2: begin
            if (core_done) begin
              tmo <= '0;
              case (state)
                MID: begin
                  mid        <= core_hash;
                  core_start <= 1'b1;
                  state      <= HASH1;
                end
                HASH1: begin
                  h_r <= core_hash;
                  if (DOUBLE_HASH) begin
                    core_start <= 1'b1;
                    state      <= HASH2;
                  end else begin
                    state <= CHECK;
                  end
                end
                default: begin
                  h_r   <= core_hash;
                  state <= CHECK;
                end
              endcase
            end else if (tmo == TMO_LAST) begin
              err   <= 1'b1;
              state <= IDLE;
            end else begin
              tmo <= tmo + 1'b1;
            end
          end
          CHECK: begin
            if (hash_count != '1) hash_count <= hash_count + 32'd1;
            if (h_r < tgt) begin
              nonce_out <= nonce;
              hash_out  <= h_r;
              found     <= 1'b1;
              state     <= IDLE;
            end else if (nonce == n_end) begin
              exhausted <= 1'b1;
              state     <= IDLE;
            end else begin
              nonce      <= nonce + 32'd1;
              tmo        <= '0;
              core_start <= 1'b1;
              state      <= HASH1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hm_nonce_sequencer.sv
// Directed bench for hm_nonce_sequencer using a scripted fixed-latency core stub.
module tb_hm_nonce_sequencer;

  localparam int LAT = 66;
  localparam logic [255:0] STD_IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] MIDS = 256'h1111222233334444555566667777888899990000aaaabbbbccccddddeeeeffff;
  localparam logic [255:0] HIT  = {1'b0, {255{1'b1}}};
  localparam logic [31:0]  MASK = 32'h5a5a0000;

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [639:0] header = '0;
  logic [31:0]  nonce_start = '0;
  logic [31:0]  nonce_end = '0;
  logic [255:0] target = '0;
  logic         core_start;
  logic [511:0] core_block;
  logic [255:0] core_iv;
  logic         core_done = 1'b0;
  logic [255:0] core_hash = '0;
  logic         busy, found, exhausted, err;
  logic [31:0]  nonce_out;
  logic [255:0] hash_out;
  logic [31:0]  hash_count;

  hm_nonce_sequencer #(.CORE_TIMEOUT(128), .DOUBLE_HASH(1'b1)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .abort(abort), .header(header),
    .nonce_start(nonce_start), .nonce_end(nonce_end), .target(target),
    .core_start(core_start), .core_block(core_block), .core_iv(core_iv),
    .core_done(core_done), .core_hash(core_hash), .busy(busy), .found(found),
    .exhausted(exhausted), .err(err), .nonce_out(nonce_out), .hash_out(hash_out),
    .hash_count(hash_count)
  );

  always #5 clk = ~clk;

  // Core stub: classifies each pass by block shape, checks IV/chaining, scripts the hash.
  logic         pend = 1'b0;
  int           cnt = 0;
  int           n_a = 0, n_b = 0, n_c = 0, bad = 0;
  logic [31:0]  last_n = '0;
  logic [31:0]  hit_nonce = '0;
  logic [511:0] last_b = '0, last_c = '0;
  logic [255:0] rsp = '0;
  logic [31:0]  nlog [$];
  bit           stub_en = 1'b1;

  always @(posedge clk) begin
    core_done <= 1'b0;
    if (!n_rst || abort || !stub_en) begin
      pend <= 1'b0;
    end else if (core_start) begin
      pend <= 1'b1;
      cnt  <= LAT - 1;
      if (core_block[31:0] == 32'h100 && core_block[255:224] == 32'h80000000) begin
        n_c    <= n_c + 1;
        last_c <= core_block;
        if (core_block[511:256] != {8{last_n ^ MASK}} || core_iv != STD_IV) bad <= bad + 1;
        rsp <= (last_n == hit_nonce) ? HIT : '1;
      end else if (core_block[31:0] == 32'h280 && core_block[383:352] == 32'h80000000) begin
        n_b    <= n_b + 1;
        last_b <= core_block;
        last_n <= core_block[415:384];
        nlog.push_back(core_block[415:384]);
        if (core_iv != MIDS) bad <= bad + 1;
        rsp <= {8{core_block[415:384] ^ MASK}};
      end else begin
        n_a <= n_a + 1;
        if (core_iv != STD_IV) bad <= bad + 1;
        rsp <= MIDS;
      end
    end else if (pend) begin
      if (cnt == 0) begin
        core_done <= 1'b1;
        core_hash <= rsp;
        pend      <= 1'b0;
      end else begin
        cnt <= cnt - 1;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk("idle_bound", 512'(busy), 512'(0));
  endtask

  task automatic setup(input logic [639:0] h, input logic [31:0] ns, input logic [31:0] ne,
                       input logic [255:0] t, input logic [31:0] hn);
    header = h; nonce_start = ns; nonce_end = ne; target = t; hit_nonce = hn;
  endtask

  logic [639:0] hdr_pat;
  int a0, b0, c0, q0, tot0, k;

  initial begin
    for (int i = 0; i < 20; i++) hdr_pat[639-32*i -: 32] = 32'hA0000000 + 32'(i);

    // Reset state
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_flags", 512'({found, exhausted, err, core_start}), 512'(0));
    chk("rst_count", 512'(hash_count), 512'(0));
    chk("rst_out", 512'({nonce_out, hash_out}), 512'(0));
    chk("rst_block", core_block, 512'(0));

    // Job 1: range 10..13, nonce 12 wins
    setup(hdr_pat, 32'h10, 32'h13, 256'(1) << 255, 32'h12);
    a0 = n_a; b0 = n_b; c0 = n_c; q0 = nlog.size();
    pulse_start();
    chk("j1_busy", 512'(busy), 512'(1));
    wait_idle();
    chk("j1_found", 512'({found, exhausted, err}), 512'(3'b100));
    chk("j1_nonce", 512'(nonce_out), 512'(32'h12));
    chk("j1_hash", 512'(hash_out), 512'(HIT));
    chk("j1_count", 512'(hash_count), 512'(3));
    chk("j1_mid_starts", 512'(n_a - a0), 512'(1));
    chk("j1_b_starts", 512'(n_b - b0), 512'(3));
    chk("j1_c_starts", 512'(n_c - c0), 512'(3));
    chk("j1_chain", 512'(bad), 512'(0));
    chk("j1_nlog", {nlog[q0], nlog[q0+1], nlog[q0+2]}, 512'({32'h10, 32'h11, 32'h12}));

    // Job 2: wrapping range, target 0 never hits
    setup(hdr_pat, 32'hFFFFFFFE, 32'h1, '0, 32'hDEAD);
    a0 = n_a; q0 = nlog.size();
    pulse_start();
    chk("j2_cleared", 512'(found), 512'(0));
    wait_idle();
    chk("j2_flags", 512'({found, exhausted, err}), 512'(3'b010));
    chk("j2_count", 512'(hash_count), 512'(4));
    chk("j2_mid_starts", 512'(n_a - a0), 512'(1));
    chk("j2_nlog", {nlog[q0], nlog[q0+1], nlog[q0+2], nlog[q0+3]},
        512'({32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h1}));
    chk("j2_nout_kept", 512'(nonce_out), 512'(32'h12));

    // Job 3: zero header, single nonce, check exact block B and C layout
    setup('0, 32'h7, 32'h7, '1, 32'h7);
    pulse_start();
    wait_idle();
    chk("j3_found", 512'({found, exhausted}), 512'(2'b10));
    chk("j3_count", 512'(hash_count), 512'(1));
    chk("j3_blk_b", last_b, {96'h0, 32'h7, 32'h80000000, 320'h0, 32'h00000280});
    chk("j3_blk_c", last_c, {{8{32'h7 ^ MASK}}, 32'h80000000, 192'h0, 32'h00000100});
    chk("j3_chain", 512'(bad), 512'(0));

    // Abort on the cycle core_done arrives for the second block-C pass
    setup(hdr_pat, 32'h20, 32'h30, '0, 32'hDEAD);
    c0 = n_c;
    pulse_start();
    k = 0;
    while (!(core_done && (n_c - c0) == 2) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk("ab_reach", 512'(k < 5000), 512'(1));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_idle", 512'(busy), 512'(0));
    chk("ab_flags", 512'({found, exhausted, err}), 512'(0));
    chk("ab_count", 512'(hash_count), 512'(1));
    chk("ab_nout_kept", 512'(nonce_out), 512'(32'h7));
    tot0 = n_a + n_b + n_c;
    repeat (100) @(negedge clk);
    chk("ab_no_start", 512'(n_a + n_b + n_c - tot0), 512'(0));

    // Core never answers: err exactly 128 cycles after core_start
    stub_en = 1'b0;
    setup(hdr_pat, 32'h5, 32'h5, '1, 32'h5);
    pulse_start();
    chk("to_cs", 512'(core_start), 512'(1));
    k = 0;
    while (!err && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("to_cycles", 512'(k), 512'(128));
    chk("to_idle", 512'(busy), 512'(0));
    stub_en = 1'b1;
    pulse_start();
    chk("to_err_clr", 512'(err), 512'(0));
    wait_idle();
    chk("to_rerun", 512'({found, err, nonce_out}), 512'({2'b10, 32'h5}));

    // Async reset mid-HASH1, then restart with a MID pass
    setup(hdr_pat, 32'h40, 32'h50, '0, 32'hDEAD);
    b0 = n_b;
    pulse_start();
    k = 0;
    while ((n_b - b0) < 1 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    repeat (10) @(negedge clk);
    chk("rs_busy_pre", 512'(busy), 512'(1));
    #2 n_rst = 1'b0;
    #1;
    chk("rs_busy", 512'(busy), 512'(0));
    chk("rs_outs", 512'({core_start, found, nonce_out, hash_count}), 512'(0));
    chk("rs_hash", 512'(hash_out), 512'(0));
    @(negedge clk);
    n_rst = 1'b1;
    a0 = n_a; b0 = n_b;
    pulse_start();
    @(negedge clk);
    chk("rs_mid_restart", 512'({n_a - a0, n_b - b0}), 512'({32'd1, 32'd0}));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("rs_abort_idle", 512'(busy), 512'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hm_nonce_sequencer.md
Name: hm_nonce_sequencer

Overview:
- Control stage directly upstream of the SHA-256 compression core. For a latched 80-byte block header it iterates a nonce range and builds the padded 512-bit message blocks.
- It sequences the core through midstate, first-hash and second-hash passes, then compares each final hash against a 256-bit target.
- Reports the first winning nonce and hash, or reports range exhaustion.
- Midstate (header bytes 0-63) is computed once per job and reused for every nonce.

Parameters:
- CORE_TIMEOUT, 128, max cycles between core_start and core_done before the sequencer flags err and returns to IDLE.
- DOUBLE_HASH, 1, 1 = SHA256(SHA256(header)); 0 = single hash (the block C pass is skipped).

Ports:
- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous active-low reset
- start  in  1  job start; honoured only in IDLE
- abort  in  1  cancel job; any state -> IDLE
- header  in  640  header words 0..19; word 0 = bits 639:608; word 19 is ignored (replaced by nonce)
- nonce_start  in  32  first nonce tested
- nonce_end  in  32  last nonce tested (inclusive)
- target  in  256  found when hash < target (unsigned)
- core_start  out  1  one-cycle pulse: core loads core_iv and core_block
- core_block  out  512  message block; word 0 = bits 511:480
- core_iv  out  256  initial chaining value for this pass
- core_done  in  1  one-cycle pulse: core_hash valid
- core_hash  in  256  core result; word 0 (H0) = bits 255:224
- busy  out  1  high in every state except IDLE
- found  out  1  level; set on hit, cleared on next accepted start or abort
- exhausted  out  1  level; set when nonce_end is tested without a hit; cleared like found
- err  out  1  level; core timeout; cleared like found
- nonce_out  out  32  winning nonce (valid while found)
- hash_out  out  256  winning hash (valid while found)
- hash_count  out  32  nonces fully tested in current job; saturates at FFFFFFFF

Behaviour:
- Reset values: all outputs 0; state IDLE; internal registers 0.
- Start in IDLE: latch header, target, nonce_start, nonce_end. Set nonce = nonce_start. Clear found/exhausted/err and hash_count. Go to MID.
- Block contents:
  - Block A = header words 0..15; IV = standard SHA-256 IV (6a09e667 ... 5be0cd19).
  - Block B = header words 16..18, nonce, 80000000, ten zero words, 00000280; IV = stored midstate.
  - Block C = first-hash words 0..7, 80000000, six zero words, 00000100; IV = standard IV.
  - No byte swapping is performed; the host supplies words in core order.
- Pass protocol (each of MID, HASH1, HASH2):
  - core_start pulses exactly once, on the first cycle in the state.
  - core_block and core_iv are stable from that cycle until core_done.
  - On core_done, core_hash is captured. MID -> stores midstate -> HASH1. HASH1 -> HASH2 (or CHECK if DOUBLE_HASH=0). HASH2 -> CHECK.
  - core_done outside a waiting state is ignored.
- CHECK (1 cycle): hash_count increments.
  - If hash < target: nonce_out/hash_out load, found=1 -> IDLE.
  - Else if nonce == nonce_end: exhausted=1 -> IDLE.
  - Else nonce = nonce+1 (mod 2^32) -> HASH1. Midstate is not recomputed.
- Wrap: nonce_end < nonce_start is legal; the range wraps through FFFFFFFF -> 00000000. nonce_start == nonce_end tests exactly one nonce.
- Per-nonce cost with DOUBLE_HASH=1: 2 core passes + 1 CHECK cycle + 2 state-entry cycles.
- Timeout: a per-pass cycle counter starts at core_start. Reaching CORE_TIMEOUT without core_done sets err=1 -> IDLE.
- Abort (highest priority; beats core_done, CHECK and start in the same cycle): next state IDLE; no further core_start; found/exhausted/err cleared; nonce_out/hash_out retained.
- start while busy: ignored.
- Asynchronous reset mid-job: immediate return to reset values; core_start low.

Test Plan:
- Stub core (fixed 66-cycle latency, scripted hashes), nonce_start=00000010, nonce_end=00000013, target=2^255; scripted hash for nonce 12 = 0x7FFF...F, others 0xFFFF...F -> exactly 1 MID + 3x(HASH1,HASH2) starts, found=1, nonce_out=00000012, hash_count=3, midstate start count 1.
- Target=0, nonce_start=FFFFFFFE, nonce_end=00000001 -> nonces FFFFFFFE,FFFFFFFF,0,1 appear in block B word 3 in order, exhausted=1, found=0, hash_count=4.
- Real SHA core, header words 0..18 = 0, nonce 0 only, target all-ones -> block B = 0,0,0,0,80000000,0x10,00000280; block C word 8 = 80000000, word 15 = 00000100; hash_out equals software SHA256d of 80 zero bytes.
- Abort asserted on the same cycle as core_done in HASH2 -> IDLE next cycle, no CHECK, found=0, hash_count unchanged, no further core_start.
- Stub core never returns core_done, CORE_TIMEOUT=128 -> err=1 exactly 128 cycles after core_start, busy=0; a subsequent start clears err and runs normally.
- n_rst pulsed low mid-HASH1 -> all outputs 0 asynchronously; start after release restarts with a MID pass.
